// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong game controller and its surrounding game logic.
// The master drives the frame tick, buttons and ball events; the slave is the controller.
interface pong_game_ctrl_if;
  logic        tick60;
  logic        start;
  logic        pause;
  logic        hit;
  logic        miss;
  logic        run;
  logic        ball_rst;
  logic [15:0] score;
  logic [1:0]  lives;
  logic [1:0]  state;
  logic        paused;

  modport master (
    output tick60, start, pause, hit, miss,
    input  run, ball_rst, score, lives, state, paused
  );

  modport slave (
    input  tick60, start, pause, hit, miss,
    output run, ball_rst, score, lives, state, paused
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve timer, BCD score, lives and game state, all outputs registered.
// Optional pause button support is compiled in when PONG_PAUSE_EN is defined.
module pong_game_ctrl #(
  parameter int unsigned LIVES_INIT  = 3,
  parameter int unsigned WAIT_FRAMES = 120
) (
  input  logic             clk,
  input  logic             reset,
  pong_game_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLAY  = 2'b01,
    SERVE = 2'b10,
    OVER  = 2'b11
  } state_e;

  localparam logic [1:0] LIVES_LD = 2'(LIVES_INIT);
  localparam logic [7:0] WAIT_LD  = 8'(WAIT_FRAMES);

  state_e      state_q, state_d;
  logic [15:0] score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic [7:0]  timer_q, timer_d;
  logic        run_q, run_d;
  logic        ball_rst_q, ball_rst_d;
  logic        paused_q, paused_d;
  logic        start_q, start_d;

  logic        start_rise;
  logic        pause_rise;
  logic        live_play;
  logic        hit_ok;
  logic        miss_ok;

  // Four-digit BCD increment that sticks at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    start_d    = bus.start;
    start_rise = bus.start & ~start_q;
  end

`ifdef PONG_PAUSE_EN
  logic pause_q, pause_d;

  always_comb begin
    pause_d    = bus.pause;
    pause_rise = bus.pause & ~pause_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pause_q <= 1'b0;
    else       pause_q <= pause_d;
  end
`else
  logic unused_pause;

  always_comb begin
    unused_pause = bus.pause;
    pause_rise   = 1'b0;
  end
`endif

  // A miss in the same cycle as a hit wins; the hit is dropped.
  always_comb begin
    live_play = (state_q == PLAY) && !paused_q;
    miss_ok   = live_play && bus.miss;
    hit_ok    = live_play && bus.hit && !bus.miss;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, OVER: if (start_rise) state_d = SERVE;
      SERVE:      if (bus.tick60 && timer_q == 8'd1) state_d = PLAY;
      PLAY:       if (miss_ok) state_d = (lives_q > 2'd1) ? SERVE : OVER;
      default:    state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    score_d    = score_q;
    lives_d    = lives_q;
    timer_d    = timer_q;
    ball_rst_d = 1'b0;
    unique case (state_q)
      IDLE, OVER: begin
        if (start_rise) begin
          score_d    = '0;
          lives_d    = LIVES_LD;
          timer_d    = WAIT_LD;
          ball_rst_d = 1'b1;
        end
      end
      SERVE: begin
        if (bus.tick60 && timer_q != 8'd0) timer_d = timer_q - 8'd1;
      end
      PLAY: begin
        if (miss_ok) begin
          if (lives_q > 2'd1) begin
            lives_d    = lives_q - 2'd1;
            timer_d    = WAIT_LD;
            ball_rst_d = 1'b1;
          end else begin
            lives_d = '0;
          end
        end else if (hit_ok) begin
          score_d = bcd_inc(score_q);
        end
      end
      default: ;
    endcase

    // paused only lives inside PLAY; run mirrors the registered state/pause pair
    if (state_d != PLAY)                      paused_d = 1'b0;
    else if (state_q == PLAY && pause_rise)   paused_d = ~paused_q;
    else                                      paused_d = paused_q;
    run_d = (state_d == PLAY) && !paused_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q    <= '0;
      lives_q    <= LIVES_LD;
      timer_q    <= '0;
      run_q      <= 1'b0;
      ball_rst_q <= 1'b0;
      paused_q   <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      score_q    <= score_d;
      lives_q    <= lives_d;
      timer_q    <= timer_d;
      run_q      <= run_d;
      ball_rst_q <= ball_rst_d;
      paused_q   <= paused_d;
      start_q    <= start_d;
    end
  end

  assign bus.run      = run_q;
  assign bus.ball_rst = ball_rst_q;
  assign bus.score    = score_q;
  assign bus.lives    = lives_q;
  assign bus.state    = state_q;
  assign bus.paused   = paused_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: start/serve, BCD scoring, lives, pause and reset behaviour.
module tb_pong_game_ctrl;

  localparam int unsigned WAIT = 120;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   rst_pulses = 0;
  logic prev_ball_rst = 1'b0;

  pong_game_ctrl_if bus ();

  pong_game_ctrl #(.LIVES_INIT(3), .WAIT_FRAMES(WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (bus.ball_rst) begin
      rst_pulses++;
      check_eq("ball_rst_consecutive", 32'(prev_ball_rst), 32'd0);
    end
    prev_ball_rst = bus.ball_rst;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      bus.tick60 = 1'b1; cyc();
      bus.tick60 = 1'b0; cyc();
    end
  endtask

  task automatic hits(input int unsigned n);
    bus.hit = 1'b1;
    for (int unsigned i = 0; i < n; i++) cyc();
    bus.hit = 1'b0;
  endtask

  task automatic pulse_miss();
    bus.miss = 1'b1; cyc(); bus.miss = 1'b0;
  endtask

  task automatic press_start();
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.tick60 = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
    bus.hit = 1'b0;    bus.miss = 1'b0;
    #22;
    check_eq("rst_state",  32'(bus.state), 32'd0);
    check_eq("rst_run",    32'(bus.run), 32'd0);
    check_eq("rst_score",  32'(bus.score), 32'h0);
    check_eq("rst_lives",  32'(bus.lives), 32'd3);
    check_eq("rst_ballrst",32'(bus.ball_rst), 32'd0);
    check_eq("rst_paused", 32'(bus.paused), 32'd0);
    reset = 1'b0;
    cyc();

    // hit/miss ignored in IDLE
    bus.hit = 1'b1; bus.miss = 1'b1; cyc(); bus.hit = 1'b0; bus.miss = 1'b0;
    check_eq("idle_ignore_score", 32'(bus.score), 32'h0);
    check_eq("idle_ignore_lives", 32'(bus.lives), 32'd3);

    press_start();
    check_eq("start_ballrst", 32'(bus.ball_rst), 32'd1);
    check_eq("start_state",   32'(bus.state), 32'd2);
    check_eq("start_lives",   32'(bus.lives), 32'd3);
    check_eq("start_score",   32'(bus.score), 32'h0);
    check_eq("start_timer",   32'(dut.timer_q), 32'd120);
    cyc();
    check_eq("ballrst_one_cycle", 32'(bus.ball_rst), 32'd0);

    ticks(1);
    check_eq("timer_dec", 32'(dut.timer_q), 32'd119);
    ticks(118);
    check_eq("serve_still", 32'(bus.state), 32'd2);
    check_eq("serve_run0",  32'(bus.run), 32'd0);
    check_eq("timer_one",   32'(dut.timer_q), 32'd1);
    ticks(1);
    check_eq("play_state", 32'(bus.state), 32'd1);
    check_eq("play_run",   32'(bus.run), 32'd1);

    hits(95);
    check_eq("score_0095", 32'(bus.score), 32'h0095);
    hits(10);
    check_eq("score_0105", 32'(bus.score), 32'h0105);

    // pause behaviour
    bus.pause = 1'b1; cyc();
`ifdef PONG_PAUSE_EN
    check_eq("pause_on",     32'(bus.paused), 32'd1);
    check_eq("pause_run0",   32'(bus.run), 32'd0);
    hits(1);
    check_eq("pause_hit_ign", 32'(bus.score), 32'h0105);
    pulse_miss();
    check_eq("pause_miss_ign", 32'(bus.lives), 32'd3);
    check_eq("pause_state",    32'(bus.state), 32'd1);
    bus.pause = 1'b0; cyc();
    bus.pause = 1'b1; cyc();
    check_eq("pause_off",     32'(bus.paused), 32'd0);
    check_eq("pause_off_run", 32'(bus.run), 32'd1);
`else
    check_eq("nopause_paused", 32'(bus.paused), 32'd0);
    check_eq("nopause_run",    32'(bus.run), 32'd1);
`endif
    bus.pause = 1'b0; cyc();

    hits(894);
    check_eq("score_0999", 32'(bus.score), 32'h0999);
    hits(1);
    check_eq("score_carry_1000", 32'(bus.score), 32'h1000);
    hits(8999);
    check_eq("score_9999", 32'(bus.score), 32'h9999);
    hits(1);
    check_eq("score_sat", 32'(bus.score), 32'h9999);

    // three misses down to game over
    rst_pulses = 0;
    pulse_miss();
    check_eq("miss1_lives", 32'(bus.lives), 32'd2);
    check_eq("miss1_state", 32'(bus.state), 32'd2);
    check_eq("miss1_timer", 32'(dut.timer_q), 32'd120);
    ticks(WAIT);
    pulse_miss();
    check_eq("miss2_lives", 32'(bus.lives), 32'd1);
    ticks(WAIT);
    check_eq("miss2_replay", 32'(bus.state), 32'd1);
    pulse_miss();
    check_eq("miss3_lives", 32'(bus.lives), 32'd0);
    check_eq("miss3_state", 32'(bus.state), 32'd3);
    check_eq("miss3_noball", 32'(bus.ball_rst), 32'd0);
    cyc();
    check_eq("miss_pulses", 32'(rst_pulses), 32'd2);
    check_eq("over_run",    32'(bus.run), 32'd0);
    hits(1);
    check_eq("over_score_held", 32'(bus.score), 32'h9999);

    // restart from OVER; hit+miss collision
    press_start();
    check_eq("restart_state", 32'(bus.state), 32'd2);
    check_eq("restart_score", 32'(bus.score), 32'h0);
    check_eq("restart_lives", 32'(bus.lives), 32'd3);
    ticks(WAIT);
    hits(7);
    pulse_miss();
    ticks(WAIT);
    check_eq("pre_coll_score", 32'(bus.score), 32'h0007);
    check_eq("pre_coll_lives", 32'(bus.lives), 32'd2);
    bus.hit = 1'b1; bus.miss = 1'b1; cyc(); bus.hit = 1'b0; bus.miss = 1'b0;
    check_eq("coll_score", 32'(bus.score), 32'h0007);
    check_eq("coll_lives", 32'(bus.lives), 32'd1);
    check_eq("coll_state", 32'(bus.state), 32'd2);

    // asynchronous reset mid-serve
    ticks(70);
    check_eq("serve_timer50", 32'(dut.timer_q), 32'd50);
    #2 reset = 1'b1;
    #1;
    check_eq("async_state", 32'(bus.state), 32'd0);
    check_eq("async_run",   32'(bus.run), 32'd0);
    check_eq("async_timer", 32'(dut.timer_q), 32'd0);
    check_eq("async_ballrst", 32'(bus.ball_rst), 32'd0);

    // start held through reset release
    bus.start = 1'b1;
    #2 reset = 1'b0;
    cyc();
    check_eq("held_start_state",   32'(bus.state), 32'd2);
    check_eq("held_start_ballrst", 32'(bus.ball_rst), 32'd1);
    cyc();
    check_eq("held_start_once", 32'(bus.ball_rst), 32'd0);
    bus.start = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter LIVES_INIT, default 3, sets lives loaded at game start; legal range 1..3.
REQ-002 Parameter WAIT_FRAMES, default 120, sets serve delay in frame ticks; legal range 1..255.
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 tick60  input  1  one-cycle pulse per frame.
REQ-006 start  input  1  level start button, synchronous to clk.
REQ-007 pause  input  1  level pause button, synchronous to clk.
REQ-008 hit  input  1  one-cycle pulse when ball strikes paddle.
REQ-009 miss  input  1  one-cycle pulse when ball passes the paddle.
REQ-010 run  output  1  enables ball and paddle motion.
REQ-011 ball_rst  output  1  one-cycle pulse that re-centres the ball and restores default velocity.
REQ-012 score  output  16  four packed BCD digits, least significant digit in [3:0].
REQ-013 lives  output  2  remaining lives, binary.
REQ-014 state  output  2  encoding: IDLE=00, PLAY=01, SERVE=10, OVER=11.
REQ-015 paused  output  1  pause flag.

Function
REQ-016 Rising-edge detection: start_rise = start & ~start_q and pause_rise = pause & ~pause_q, where start_q and pause_q are one-cycle registered copies.
REQ-017 IDLE: run=0; on start_rise, the next cycle sets score=0, lives=LIVES_INIT, timer=WAIT_FRAMES, state=SERVE, and pulses ball_rst.
REQ-018 SERVE: run=0; on each tick60, timer decrements; tick60 with timer==1 moves state to PLAY on the next cycle.
REQ-019 PLAY: run=~paused; hit and miss are sampled only while in PLAY with paused=0.
REQ-020 hit: score increments by one in BCD with decimal carry across all four digits; score saturates at 9999.
REQ-021 miss with lives>1: next cycle sets lives=lives-1, timer=WAIT_FRAMES, state=SERVE, and pulses ball_rst.
REQ-022 miss with lives==1: next cycle sets lives=0 and state=OVER; ball_rst does not pulse.
REQ-023 hit and miss in the same cycle: miss is processed and hit is discarded.
REQ-024 OVER: run=0 and score is held; start_rise performs the IDLE start action of REQ-017.
REQ-025 In IDLE, SERVE and OVER, hit, miss and pause are ignored.
REQ-026 ball_rst is asserted for exactly one cycle per SERVE entry and never in two consecutive cycles.
REQ-027 All outputs are registered; response latency to every qualifying input is one clk cycle.
REQ-028 The timer is 8 bits wide and is only loaded or decremented within SERVE.

Reset
REQ-029 Reset asynchronously forces: state=IDLE, score=0, lives=LIVES_INIT, timer=0, run=0, ball_rst=0, paused=0, start_q=0, pause_q=0.
REQ-030 Reset asserted mid-game aborts immediately, with no ball_rst pulse.
REQ-031 If start is held high through reset release, one start_rise is detected on the first clock after release.

Configuration
REQ-032 Macro PONG_PAUSE_EN defined: in PLAY, pause_rise toggles paused; leaving PLAY clears paused; while paused=1, run=0 and hit/miss are ignored.
REQ-033 Macro PONG_PAUSE_EN undefined: pause is ignored, paused is tied to 0, and no pause_q register exists.

Verification
REQ-034 Reset, then start pulse -> ball_rst high one cycle, state=10, lives=3, score=0000; after 120 tick60 pulses, state=01 and run=1.
REQ-035 In PLAY, 10 hit pulses with score=0095 -> score=0105; preload score=9999 then hit -> score remains 9999.
REQ-036 In PLAY with lives=3, three miss pulses, each with serve wait completed between -> lives 2, 1, 0; state=11 after the third miss; ball_rst pulses exactly twice.
REQ-037 hit and miss in the same cycle with score=0007 and lives=2 -> score=0007, lives=1, state=10.
REQ-038 With PONG_PAUSE_EN: pause rise in PLAY -> paused=1, run=0, a hit is ignored; second pause rise -> paused=0, run=1. Without PONG_PAUSE_EN: paused stays 0.
REQ-039 Reset asserted in SERVE at timer=50 -> state=00, run=0, timer=0 immediately, with no clock edge required.
